// File: rtl/hw_ctrl_pkg.sv
// Shared constants and helpers for the hw_ctrl_seq beat sequencer.
package hw_ctrl_pkg;

  localparam logic [2:0] W_IDLE  = 3'b000;
  localparam logic [2:0] W1      = 3'b001;
  localparam logic [2:0] W2      = 3'b010;
  localparam logic [2:0] W3      = 3'b100;

  localparam logic [2:0] SW_PROG = 3'b000;

  // Caller truncates the result to the vector width.
  function automatic logic [31:0] irq_vector(input logic [31:0] base,
                                             input logic [31:0] stride,
                                             input logic [31:0] idx);
    return base + idx * stride;
  endfunction

endpackage

// File: rtl/hw_ctrl_seq_if.sv
// Console, decoder and interrupt signals of the hw_ctrl_seq sequencer.
interface hw_ctrl_seq_if #(
  parameter int NIRQ = 4,
  parameter int VECW = 8
);
  logic            run;
  logic [2:0]      sw;
  logic            short_i;
  logic            long_i;
  logic            stop_i;
  logic            set_st0_i;
  logic            iret_i;
  logic [NIRQ-1:0] irq;
  logic [2:0]      w;
  logic            running;
  logic            st0;
  logic            st1;
  logic            int_en;
  logic            int_ack;
  logic [VECW-1:0] int_vec;

  modport master (
    output run, sw, short_i, long_i, stop_i, set_st0_i, iret_i, irq,
    input  w, running, st0, st1, int_en, int_ack, int_vec
  );

  modport slave (
    input  run, sw, short_i, long_i, stop_i, set_st0_i, iret_i, irq,
    output w, running, st0, st1, int_en, int_ack, int_vec
  );
endinterface

// File: rtl/irq_arbiter.sv
// Picks one pending interrupt channel. Fixed priority (lowest index) by default;
// define HW_CTRL_RR_PRIO_EN for round-robin starting after the last grant.
module irq_arbiter #(
  parameter int NIRQ = 4,
  parameter int IDXW = 2
) (
  input  logic [NIRQ-1:0] pending,
  input  logic [IDXW-1:0] last,
  output logic [NIRQ-1:0] grant,
  output logic [IDXW-1:0] idx
);

`ifdef HW_CTRL_RR_PRIO_EN
  // Walk from farthest to nearest so the channel right after last wins.
  always_comb begin
    grant = '0;
    idx   = '0;
    for (int n = NIRQ; n >= 1; n--) begin
      if (pending[IDXW'((int'(last) + n) % NIRQ)]) begin
        grant = '0;
        grant[IDXW'((int'(last) + n) % NIRQ)] = 1'b1;
        idx   = IDXW'((int'(last) + n) % NIRQ);
      end
    end
  end
`else
  logic unused_last;
  assign unused_last = ^last;

  always_comb begin
    grant = '0;
    idx   = '0;
    for (int i = NIRQ - 1; i >= 0; i--) begin
      if (pending[i]) begin
        grant    = '0;
        grant[i] = 1'b1;
        idx      = IDXW'(i);
      end
    end
  end
`endif

endmodule

// File: rtl/hw_ctrl_seq.sv
// Instruction beat sequencer (W1/W2/W3) with vectored interrupt-cycle entry.
// Channel selection policy follows HW_CTRL_RR_PRIO_EN (see irq_arbiter).
module hw_ctrl_seq
  import hw_ctrl_pkg::*;
#(
  parameter int              NIRQ       = 4,
  parameter int              VECW       = 8,
  parameter logic [VECW-1:0] VEC_BASE   = 8'hE0,
  parameter int              VEC_STRIDE = 4
) (
  input logic          clk,
  input logic          clr,
  hw_ctrl_seq_if.slave bus
);

  // state (w) | meaning
  // 000       | halted, waiting for run
  // 001       | W1 (interrupt cycle: ack beat when st1=1)
  // 010       | W2 (iret_i honoured here; final beat of interrupt cycle)
  // 100       | W3, only reached when long_i extends an instruction

  localparam int IDXW = (NIRQ > 1) ? $clog2(NIRQ) : 1;

  logic [2:0]      w;
  logic            running, st0, st1, int_en, int_ack, stop_pend;
  logic [VECW-1:0] int_vec;
  logic [NIRQ-1:0] irq_s, irq_d, irq_rise, pending, grant, ack_clr;
  logic [IDXW-1:0] arb_idx, last_idx;
  logic [2:0]      sw_q;
  logic            instr_end, accept;

  irq_arbiter #(.NIRQ(NIRQ), .IDXW(IDXW)) u_arb (
    .pending (pending),
    .last    (last_idx),
    .grant   (grant),
    .idx     (arb_idx)
  );

  assign irq_rise = irq_s & ~irq_d;

  always_comb begin
    instr_end = 1'b0;
    if (running) begin
      case (w)
        W1:      instr_end = !st1 && bus.short_i;
        W2:      instr_end = st1 || !bus.long_i;
        W3:      instr_end = 1'b1;
        default: instr_end = 1'b0;
      endcase
    end
  end

  assign accept  = instr_end && !st1 && (bus.sw == SW_PROG) && int_en && (|pending);
  assign ack_clr = accept ? grant : '0;

  always_ff @(posedge clk) begin
    if (clr) begin
      running   <= 1'b0;
      w         <= W_IDLE;
      st0       <= 1'b0;
      st1       <= 1'b0;
      int_en    <= 1'b1;
      int_ack   <= 1'b0;
      int_vec   <= '0;
      pending   <= '0;
      irq_s     <= '0;
      irq_d     <= '0;
      sw_q      <= SW_PROG;
      stop_pend <= 1'b0;
      last_idx  <= IDXW'(NIRQ - 1);
    end else begin
      irq_s   <= bus.irq;
      irq_d   <= irq_s;
      sw_q    <= bus.sw;
      int_ack <= 1'b0;
      // A fresh edge on the channel being acknowledged keeps it pending.
      pending <= (pending & ~ack_clr) | irq_rise;

      if (!running) begin
        if (bus.run) begin
          running <= 1'b1;
          w       <= W1;
        end
      end else if (!instr_end) begin
        w <= (w == W1) ? W2 : W3;
        if (w == W2 && !st1 && bus.iret_i) int_en <= 1'b1;
      end else if (st1) begin
        st1       <= 1'b0;
        stop_pend <= 1'b0;
        if (stop_pend) begin
          running <= 1'b0;
          w       <= W_IDLE;
        end else begin
          w <= W1;
        end
      end else begin
        st0 <= bus.set_st0_i;
        if (w == W2 && bus.iret_i) int_en <= 1'b1;
        if (accept) begin
          st1       <= 1'b1;
          w         <= W1;
          int_ack   <= 1'b1;
          int_en    <= 1'b0;
          int_vec   <= VECW'(irq_vector(32'(VEC_BASE), 32'(VEC_STRIDE), 32'(arb_idx)));
          last_idx  <= arb_idx;
          stop_pend <= bus.stop_i;
        end else if (bus.stop_i) begin
          running <= 1'b0;
          w       <= W_IDLE;
        end else begin
          w <= W1;
        end
      end

      if (bus.sw != sw_q) st0 <= 1'b0;
    end
  end

  assign bus.w       = w;
  assign bus.running = running;
  assign bus.st0     = st0;
  assign bus.st1     = st1;
  assign bus.int_en  = int_en;
  assign bus.int_ack = int_ack;
  assign bus.int_vec = int_vec;

endmodule

// File: doc/hw_ctrl_seq.md
HW_CTRL_SEQ -- requirements
Module: hw_ctrl_seq

Interface
REQ-001 Parameter NIRQ, default 4, is the number of interrupt request channels (1..8).
REQ-002 Parameter VECW, default 8, is the interrupt vector width.
REQ-003 Parameter VEC_BASE, default 8'hE0, is the vector of channel 0.
REQ-004 Parameter VEC_STRIDE, default 4, is the vector spacing between channels.
REQ-005 The block has one clock; reset is synchronous and active-high.
REQ-006 Ports are:
- clk  in  1  clock; all state changes on the rising edge.
- clr  in  1  synchronous active-high reset.
- run  in  1  console start pulse.
- sw  in  3  console mode {swc,swb,swa}; 000 = program execution.
- short_i  in  1  decoder: end instruction after W1.
- long_i  in  1  decoder: extend instruction to W3.
- stop_i  in  1  decoder: halt after the current instruction.
- set_st0_i  in  1  decoder: enter phase st0 at instruction end.
- iret_i  in  1  decoder: IRET executing, valid in W2.
- irq  in  NIRQ  interrupt requests, level, asynchronous to the program.
- w  out  3  one-hot beat {W3,W2,W1}.
- running  out  1  sequencer active.
- st0  out  1  second-phase flag.
- st1  out  1  interrupt-service cycle flag.
- int_en  out  1  interrupts enabled.
- int_ack  out  1  one-cycle acknowledge pulse.
- int_vec  out  VECW  vector of the channel being serviced.

Function
REQ-007 A run pulse while running=0 shall set running=1, with w=001 on the next cycle; run while running=1 shall be ignored.
REQ-008 Beat transitions while running: W1->W1 if short_i, else W1->W2; W2->W3 if long_i, else W2->W1; W3->W1. A transition back to W1 is the instruction end.
REQ-009 If stop_i is high in the final beat of an instruction, the sequencer shall halt at instruction end: running=0, w=000.
REQ-010 At instruction end, set_st0_i=1 shall set st0; st0 shall clear at the end of the next instruction unless set_st0_i is asserted again. Any change of sw shall clear st0 on the next cycle.
REQ-011 A rising edge on irq[k], sampled through one register stage, shall set pending[k]; the block shall see a rising edge one cycle after it arrives.
REQ-012 At instruction end, if sw==000 & int_en & |pending & !st1, the next cycle shall start an interrupt cycle: st1=1, exactly 2 beats (W1,W2), short_i/long_i ignored.
REQ-013 In W1 of the interrupt cycle the block shall:
- pulse int_ack;
- drive int_vec = VEC_BASE + idx*VEC_STRIDE, computed modulo 2^VECW and held until the next acceptance;
- clear pending[idx];
- clear int_en.
REQ-014 st1 shall clear at the end of the interrupt cycle.
REQ-015 iret_i=1 in W2 shall set int_en at the end of that beat.
REQ-016 A new edge on the channel being acknowledged in the same cycle shall leave it pending (set wins over clear).
REQ-017 stop_i and an interrupt acceptance at the same instruction end: the interrupt cycle runs first, then the sequencer halts.
REQ-018 While running=0, pending bits shall keep accumulating; no interrupt cycle shall start.

Reset
REQ-019 clr=1 shall force, at the next rising edge: running=0, w=000, st0=0, st1=0, int_en=1, int_ack=0, int_vec=0, pending=0, edge registers=0. This holds mid-instruction and mid-interrupt-cycle.

Configuration
REQ-020 With HW_CTRL_RR_PRIO_EN defined, the channel is chosen round-robin, starting after the last acknowledged channel.
REQ-021 Without HW_CTRL_RR_PRIO_EN, fixed priority applies: the lowest pending index wins.

Structure
REQ-022 Package hw_ctrl_pkg shall hold:
- the beat one-hot constants W1/W2/W3;
- the sw mode constants;
- the vector computation function.
REQ-023 Channel selection shall be a sub-module irq_arbiter (inputs pending and last grant; output one-hot grant and index).

Verification
REQ-024 The bench shall cover:
- clr, then run; short_i=0, long_i=1 -> w 001,010,100,001.
- short_i=1 at W1 -> w stays 001 every cycle; stop_i with short_i -> running=0, w=000 next cycle.
- NIRQ=4, fixed priority, edges on irq[2] and irq[1] in the same cycle -> first acknowledgement has int_vec=E4, int_en=0; iret_i in W2 -> next acknowledgement has int_vec=E8.
- Round-robin build, all four pending, last grant 3 -> service order 0,1,2,3.
- clr asserted in W2 of an interrupt cycle -> all outputs at reset values next cycle, int_en=1.
- sw changes 000->001 with st0=1 -> st0=0 next cycle; irq edge while sw=001 -> pending held, no st1.
